placar_pontuacao: RTL and testbench
===================================

PLACAR_PONTUACAO -- requirements
Module: placar_pontuacao

Interface
REQ-001 SHALL have parameter NUM_TIMES, default 2, number of team score registers (2..8).
REQ-002 SHALL have parameter PONTOS_W, default 7, width of each score.
REQ-003 SHALL have parameter MAX_PONTOS, default 99, highest legal score (< 2**PONTOS_W).
REQ-004 SHALL have parameter BUZZER_CICLOS, default 25_000_000, buzzer on-time in clocks (>= 2).
REQ-005 SHALL have port clk  in  1  sole clock, rising edge.
REQ-006 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have ports btn_a, btn_b, btn_c  in  1 each  raw asynchronous buttons, active-high, worth 1/2/3 points.
REQ-008 SHALL have port modo_sub  in  1  0 = add, 1 = subtract.
REQ-009 SHALL have port sel_time  in  $clog2(NUM_TIMES)  target team index.
REQ-010 SHALL have port limpar  in  1  synchronous clear of all scores.
REQ-011 SHALL have port pontos  out  NUM_TIMES*PONTOS_W  packed scores, team 0 in the LSBs.
REQ-012 SHALL have port buzzer  out  1  invalid-operation alarm.
REQ-013 SHALL have port led_ok  out  1  one-cycle pulse per accepted operation.

Function
REQ-014 Each button SHALL pass a 2-flop synchroniser plus a previous-value flop; an event is ff2 & ~prev (single event per press, held buttons ignored).
REQ-015 Same-cycle events SHALL resolve by priority C > B > A; only the winner is applied, the others are discarded.
REQ-016 Add SHALL be accepted only if score + value <= MAX_PONTOS; otherwise score is unchanged and the event is invalid.
REQ-017 Subtract SHALL be accepted only if value <= score; otherwise score is unchanged and the event is invalid.
REQ-018 sel_time >= NUM_TIMES SHALL make the event invalid with no score change.
REQ-019 modo_sub and sel_time SHALL be sampled in the cycle the event is detected.
REQ-020 Latency: with a button sampled high at clock edge k, the score SHALL update at edge k+2, and led_ok SHALL be high for the cycle after k+2.
REQ-021 limpar SHALL zero all scores at the next edge, override any same-cycle event, and force the buzzer FSM to OCIOSO.
REQ-022 Buzzer FSM states: OCIOSO (buzzer=0) and ALARME (buzzer=1).
REQ-023 An invalid event SHALL move OCIOSO->ALARME and load the counter with BUZZER_CICLOS-1.
REQ-024 ALARME SHALL decrement each cycle and return to OCIOSO after exactly BUZZER_CICLOS high cycles.
REQ-025 An invalid event during ALARME SHALL reload the counter; valid events SHALL still be applied during ALARME.

Reset
REQ-026 rst_n low SHALL asynchronously clear all scores, synchroniser flops and the counter, and set buzzer=0, led_ok=0, state OCIOSO.
REQ-027 Reset SHALL be released synchronously to clk by the system; a press in progress at release SHALL NOT generate an event until the button is released and pressed again.

Configuration
REQ-028 Macro PLACAR_BCD_EN, when defined, SHALL add output pontos_bcd (NUM_TIMES*8), two BCD digits per team, registered one cycle after pontos; MAX_PONTOS SHALL then be <= 99.
REQ-029 Without PLACAR_BCD_EN the port and conversion logic SHALL be absent and all other behaviour identical.

Structure
REQ-030 Package placar_pkg SHALL hold constants PONTOS_A=1, PONTOS_B=2, PONTOS_C=3 and enum estado_buzzer_t {OCIOSO, ALARME}.
REQ-031 Sub-module sincronizador_borda (2-flop sync + rising-edge detect, async active-low reset) SHALL be instantiated once per button.

Verification (BUZZER_CICLOS=8 on bench)
REQ-032 Reset, team 0 = 0, add, press btn_c -> pontos[team0] = 3 at edge k+2, led_ok one pulse, buzzer 0.
REQ-033 Team 1 = 1, subtract, press btn_b -> team 1 stays 1, buzzer high exactly 8 cycles.
REQ-034 Team 0 = 98, add, press btn_b -> unchanged, buzzer; then btn_a -> 99, led_ok pulse.
REQ-035 btn_a and btn_c rise in the same cycle on team 0 = 0 -> score 3, single led_ok pulse; button held 20 cycles -> no further change.
REQ-036 limpar asserted in the same cycle as an event, with buzzer active -> all scores 0 next edge, buzzer 0, no led_ok.
REQ-037 rst_n pulsed low mid-ALARME with scores 10/20 -> immediate zeros and buzzer 0; with PLACAR_BCD_EN, a score of 57 -> pontos_bcd = 0x57 one cycle later.

Source files
------------

// File: rtl/placar_pkg.sv
// Shared constants and types for the scoreboard (placar_pontuacao).
package placar_pkg;

  localparam int unsigned PONTOS_A = 1;
  localparam int unsigned PONTOS_B = 2;
  localparam int unsigned PONTOS_C = 3;

  typedef enum logic {
    OCIOSO = 1'b0,
    ALARME = 1'b1
  } estado_buzzer_t;

  // Two BCD digits (tens, units) for a value in 0..99.
  function automatic logic [7:0] para_bcd(input int unsigned v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

endpackage

// File: rtl/sincronizador_borda.sv
// Two-flop synchroniser with rising-edge detection for one raw button.
// Detection stays disarmed after reset until the synchronised button has
// been observed low, so a press held across reset release is ignored.
module sincronizador_borda (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic evento
);

  logic ff1, ff2, prev;
  logic vld1, vld2;
  logic armado;

  // Synchroniser chain, previous-value flop and arming logic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff1    <= 1'b0;
      ff2    <= 1'b0;
      prev   <= 1'b0;
      vld1   <= 1'b0;
      vld2   <= 1'b0;
      armado <= 1'b0;
    end else begin
      ff1  <= btn;
      ff2  <= ff1;
      prev <= ff2;
      vld1 <= 1'b1;
      vld2 <= vld1;
      // vld2 marks ff2 as holding a real post-reset sample
      if (vld2 && !ff2)
        armado <= 1'b1;
    end
  end

  assign evento = ff2 & ~prev & armado;

endmodule

// File: rtl/placar_pontuacao.sv
// Multi-team scoreboard: buttons worth 1/2/3 points add to or subtract from
// the selected team score; invalid operations sound the buzzer.
// Optional feature: define PLACAR_BCD_EN to add the registered pontos_bcd output.
module placar_pontuacao
  import placar_pkg::*;
#(
  parameter int unsigned NUM_TIMES     = 2,
  parameter int unsigned PONTOS_W      = 7,
  parameter int unsigned MAX_PONTOS    = 99,
  parameter int unsigned BUZZER_CICLOS = 25_000_000
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            btn_a,
  input  logic                            btn_b,
  input  logic                            btn_c,
  input  logic                            modo_sub,
  input  logic [$clog2(NUM_TIMES)-1:0]    sel_time,
  input  logic                            limpar,
  output logic [NUM_TIMES*PONTOS_W-1:0]   pontos,
  output logic                            buzzer,
  output logic                            led_ok
`ifdef PLACAR_BCD_EN
  ,
  output logic [NUM_TIMES*8-1:0]          pontos_bcd
`endif
);

  localparam int unsigned CNT_W = $clog2(BUZZER_CICLOS);

  logic [PONTOS_W-1:0] placar [NUM_TIMES];
  logic                ev_a, ev_b, ev_c;
  logic                houve;
  logic [1:0]          valor;
  int unsigned         sel_idx;
  logic                sel_ok;
  logic [PONTOS_W-1:0] atual;
  logic [PONTOS_W:0]   soma;
  logic [PONTOS_W-1:0] novo;
  logic                aceito;
  logic                invalido;

  estado_buzzer_t      estado, prox_estado;
  logic [CNT_W-1:0]    cont, prox_cont;

  sincronizador_borda u_sync_a (.clk(clk), .rst_n(rst_n), .btn(btn_a), .evento(ev_a));
  sincronizador_borda u_sync_b (.clk(clk), .rst_n(rst_n), .btn(btn_b), .evento(ev_b));
  sincronizador_borda u_sync_c (.clk(clk), .rst_n(rst_n), .btn(btn_c), .evento(ev_c));

  // Pick the winning event (C > B > A) and validate it against the target score.
  always_comb begin
    houve   = ev_a | ev_b | ev_c;
    valor   = 2'd0;
    if (ev_c)      valor = 2'(PONTOS_C);
    else if (ev_b) valor = 2'(PONTOS_B);
    else if (ev_a) valor = 2'(PONTOS_A);

    sel_idx = 32'(sel_time);
    sel_ok  = (sel_idx < NUM_TIMES);
    atual   = '0;
    for (int unsigned i = 0; i < NUM_TIMES; i++)
      if (i == sel_idx) atual = placar[i];

    soma     = {1'b0, atual} + (PONTOS_W+1)'(valor);
    novo     = atual;
    aceito   = 1'b0;
    if (houve && sel_ok) begin
      if (modo_sub) begin
        if (PONTOS_W'(valor) <= atual) begin
          aceito = 1'b1;
          novo   = atual - PONTOS_W'(valor);
        end
      end else if (soma <= (PONTOS_W+1)'(MAX_PONTOS)) begin
        aceito = 1'b1;
        novo   = soma[PONTOS_W-1:0];
      end
    end
    invalido = houve & ~aceito;
  end

  // Score registers and accept pulse; limpar wins over any same-cycle event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_TIMES; i++) placar[i] <= '0;
      led_ok <= 1'b0;
    end else if (limpar) begin
      for (int unsigned i = 0; i < NUM_TIMES; i++) placar[i] <= '0;
      led_ok <= 1'b0;
    end else begin
      led_ok <= aceito;
      for (int unsigned i = 0; i < NUM_TIMES; i++)
        if (aceito && i == sel_idx) placar[i] <= novo;
    end
  end

  // Pack team scores, team 0 in the LSBs.
  always_comb begin
    pontos = '0;
    for (int unsigned i = 0; i < NUM_TIMES; i++)
      pontos[i*PONTOS_W +: PONTOS_W] = placar[i];
  end

  // Buzzer FSM state and on-time counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado <= OCIOSO;
      cont   <= '0;
    end else begin
      estado <= prox_estado;
      cont   <= prox_cont;
    end
  end

  // Buzzer FSM next state: invalid events (re)load the on-time counter.
  always_comb begin
    prox_estado = estado;
    prox_cont   = cont;
    if (limpar) begin
      prox_estado = OCIOSO;
      prox_cont   = '0;
    end else begin
      case (estado)
        OCIOSO: begin
          if (invalido) begin
            prox_estado = ALARME;
            prox_cont   = CNT_W'(BUZZER_CICLOS - 1);
          end
        end
        ALARME: begin
          if (invalido) begin
            prox_cont = CNT_W'(BUZZER_CICLOS - 1);
          end else if (cont == '0) begin
            prox_estado = OCIOSO;
          end else begin
            prox_cont = cont - 1'b1;
          end
        end
        default: begin
          prox_estado = OCIOSO;
          prox_cont   = '0;
        end
      endcase
    end
  end

  assign buzzer = (estado == ALARME);

`ifdef PLACAR_BCD_EN
  // BCD view of each score, one cycle behind pontos.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pontos_bcd <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_TIMES; i++)
        pontos_bcd[i*8 +: 8] <= para_bcd(32'(placar[i]));
    end
  end
`endif

endmodule

// File: tb/tb_placar_pontuacao.sv
// Directed self-checking bench for placar_pontuacao (3 teams, 8-cycle buzzer).
module tb_placar_pontuacao;

  localparam int unsigned NT = 3;
  localparam int unsigned PW = 7;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            btn_a = 1'b0, btn_b = 1'b0, btn_c = 1'b0;
  logic            modo_sub = 1'b0;
  logic [1:0]      sel_time = 2'd0;
  logic            limpar = 1'b0;
  logic [NT*PW-1:0] pontos;
  logic            buzzer;
  logic            led_ok;
`ifdef PLACAR_BCD_EN
  logic [NT*8-1:0] pontos_bcd;
`endif

  placar_pontuacao #(
    .NUM_TIMES(NT),
    .PONTOS_W(PW),
    .MAX_PONTOS(99),
    .BUZZER_CICLOS(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn_a(btn_a),
    .btn_b(btn_b),
    .btn_c(btn_c),
    .modo_sub(modo_sub),
    .sel_time(sel_time),
    .limpar(limpar),
    .pontos(pontos),
    .buzzer(buzzer),
    .led_ok(led_ok)
`ifdef PLACAR_BCD_EN
    ,
    .pontos_bcd(pontos_bcd)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int n_led  = 0;
  int n_buzz = 0;

  // Running count of led_ok and buzzer high cycles.
  always @(negedge clk) begin
    if (led_ok) n_led++;
    if (buzzer) n_buzz++;
  end

  typedef struct {
    logic [2:0] btn;   // {c,b,a}
    logic       sub;
    logic [1:0] sel;
    int         e0, e1, e2;
    int         e_led;
    int         e_buzz;
  } vec_t;

  vec_t tab[12];

  function automatic longint pk(input int a, input int b, input int c);
    return longint'(a) + (longint'(b) << 7) + (longint'(c) << 14);
  endfunction

  task automatic chk(input string nome, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nome, act, exp);
    end
  endtask

  task automatic press(input logic [2:0] b, input logic sub, input logic [1:0] sel,
                       input int hold, input int gap);
    @(negedge clk);
    {btn_c, btn_b, btn_a} = b;
    modo_sub = sub;
    sel_time = sel;
    repeat (hold) @(negedge clk);
    {btn_c, btn_b, btn_a} = 3'b000;
    repeat (gap) @(negedge clk);
  endtask

  task automatic somar(input logic [1:0] sel, input int n);
    repeat (n / 3) press(3'b100, 1'b0, sel, 3, 3);
    if (n % 3 == 1) press(3'b001, 1'b0, sel, 3, 3);
    if (n % 3 == 2) press(3'b010, 1'b0, sel, 3, 3);
  endtask

  int led0, buzz0;

  initial begin
    tab[0]  = '{3'b100, 1'b0, 2'd0, 6, 0, 0, 1, 0};
    tab[1]  = '{3'b001, 1'b0, 2'd1, 6, 1, 0, 1, 0};
    tab[2]  = '{3'b010, 1'b1, 2'd1, 6, 1, 0, 0, 8};
    tab[3]  = '{3'b001, 1'b1, 2'd1, 6, 0, 0, 1, 0};
    tab[4]  = '{3'b010, 1'b0, 2'd3, 6, 0, 0, 0, 8};
    tab[5]  = '{3'b101, 1'b0, 2'd2, 6, 0, 3, 1, 0};
    tab[6]  = '{3'b011, 1'b1, 2'd2, 6, 0, 1, 1, 0};
    tab[7]  = '{3'b100, 1'b1, 2'd2, 6, 0, 1, 0, 8};
    tab[8]  = '{3'b001, 1'b1, 2'd2, 6, 0, 0, 1, 0};
    tab[9]  = '{3'b100, 1'b1, 2'd0, 3, 0, 0, 1, 0};
    tab[10] = '{3'b010, 1'b1, 2'd0, 1, 0, 0, 1, 0};
    tab[11] = '{3'b111, 1'b0, 2'd1, 1, 3, 0, 1, 0};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_pontos", pontos, 0);
    chk("rst_buzzer", buzzer, 0);
    chk("rst_led", led_ok, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Latency: btn_c sampled at edge k -> score at k+2, led_ok the cycle after
    btn_c = 1'b1; modo_sub = 1'b0; sel_time = 2'd0;
    @(posedge clk);              // edge k
    @(posedge clk); #1;          // edge k+1
    chk("lat_k1_pontos", pontos, 0);
    chk("lat_k1_led", led_ok, 0);
    @(posedge clk); #1;          // edge k+2
    chk("lat_k2_pontos", pontos, pk(3, 0, 0));
    chk("lat_k2_led", led_ok, 1);
    chk("lat_k2_buzzer", buzzer, 0);
    @(posedge clk); #1;
    chk("lat_k3_led", led_ok, 0);
    @(negedge clk); btn_c = 1'b0;
    repeat (5) @(negedge clk);

    // Table-driven single operations
    for (int i = 0; i < 12; i++) begin
      led0 = n_led; buzz0 = n_buzz;
      press(tab[i].btn, tab[i].sub, tab[i].sel, 4, 14);
      chk($sformatf("vec%0d_pontos", i), pontos, pk(tab[i].e0, tab[i].e1, tab[i].e2));
      chk($sformatf("vec%0d_led", i), n_led - led0, tab[i].e_led);
      chk($sformatf("vec%0d_buzz", i), n_buzz - buzz0, tab[i].e_buzz);
    end

    // Upper bound: team 0 from 1 to 98, then +2 rejected, +1 accepted, +1 rejected
    somar(2'd0, 97);
    chk("t0_98", pontos, pk(98, 3, 0));
    led0 = n_led; buzz0 = n_buzz;
    press(3'b010, 1'b0, 2'd0, 4, 14);
    chk("t0_98_plus2", pontos, pk(98, 3, 0));
    chk("t0_98_plus2_buzz", n_buzz - buzz0, 8);
    chk("t0_98_plus2_led", n_led - led0, 0);
    led0 = n_led;
    press(3'b001, 1'b0, 2'd0, 4, 14);
    chk("t0_99", pontos, pk(99, 3, 0));
    chk("t0_99_led", n_led - led0, 1);
    buzz0 = n_buzz;
    press(3'b001, 1'b0, 2'd0, 4, 14);
    chk("t0_99_plus1", pontos, pk(99, 3, 0));
    chk("t0_99_plus1_buzz", n_buzz - buzz0, 8);

    // Held button: one event only
    led0 = n_led;
    press(3'b001, 1'b0, 2'd2, 20, 6);
    chk("held_pontos", pontos, pk(99, 3, 1));
    chk("held_led", n_led - led0, 1);

    // limpar in the event cycle with buzzer active
    press(3'b100, 1'b1, 2'd2, 4, 0);   // 1 - 3 invalid
    chk("pre_clr_buzzer", buzzer, 1);
    led0 = n_led;
    btn_a = 1'b1; modo_sub = 1'b0; sel_time = 2'd1;
    @(posedge clk);                    // edge k
    @(posedge clk);                    // edge k+1
    @(negedge clk); limpar = 1'b1;     // event cycle
    @(posedge clk); #1;
    chk("clr_pontos", pontos, 0);
    chk("clr_buzzer", buzzer, 0);
    chk("clr_led", led_ok, 0);
    @(negedge clk); limpar = 1'b0; btn_a = 1'b0;
    @(posedge clk); #1;
    chk("clr_led_after", n_led - led0 + int'(led_ok), 0);
    repeat (4) @(negedge clk);

    // Async reset mid-ALARME with scores 10/20, button held across reset
    somar(2'd0, 10);
    somar(2'd1, 20);
    chk("pre_rst_pontos", pontos, pk(10, 20, 0));
    press(3'b010, 1'b0, 2'd3, 4, 2);
    chk("pre_rst_buzzer", buzzer, 1);
    @(posedge clk); #2;
    rst_n = 1'b0; btn_a = 1'b1; modo_sub = 1'b0; sel_time = 2'd0;
    #1;
    chk("rst_mid_pontos", pontos, 0);
    chk("rst_mid_buzzer", buzzer, 0);
    chk("rst_mid_led", led_ok, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    led0 = n_led;
    repeat (10) @(negedge clk);
    chk("held_rel_pontos", pontos, 0);
    chk("held_rel_led", n_led - led0, 0);
    btn_a = 1'b0;
    repeat (4) @(negedge clk);
    press(3'b001, 1'b0, 2'd0, 4, 6);
    chk("after_rel_pontos", pontos, pk(1, 0, 0));

`ifdef PLACAR_BCD_EN
    somar(2'd1, 57);
    @(negedge clk);
    chk("bcd_t1", pontos_bcd[15:8], 8'h57);
    chk("bcd_t0", pontos_bcd[7:0], 8'h01);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
